// File: rtl/request_encoder32_5_pkg.sv
// Shared definitions for the 32->5 request encoder.
//   - N, IDX_W, CNT_W : vector width, index width, emitted-count width
//   - req_state_e     : scanner states (IDLE=0, SCAN=1)
//   - idx_to_onehot   : decoder function, same mapping as the register-select decoder
package request_encoder32_5_pkg;

    localparam int N     = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } req_state_e;

    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
        return N'(1) << i;
    endfunction

endpackage

// File: rtl/request_encoder32_5_penc.sv
// priority_enc32_5: combinational lowest-set-bit encoder.
//   in  [31:0] : vector to encode
//   idx [4:0]  : index of the lowest set bit (0 when in == 0)
//   any        : 1 when any bit of in is set
// Two-level tree: four 8-bit groups each resolve a 3-bit local index, then
// the lowest non-empty group supplies the upper 2 bits.
module priority_enc32_5
    import request_encoder32_5_pkg::*;
(
    input  logic [N-1:0]     in,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [3:0] grp_any;
    logic [2:0] grp_low [4];
    logic [1:0] grp_sel;

    always_comb begin
        grp_any = '0;
        grp_sel = '0;
        for (int g = 0; g < 4; g++) begin
            grp_low[g] = '0;
            grp_any[g] = |in[g*8 +: 8];
            // Scan downwards so the lowest set bit is the last one written.
            for (int b = 7; b >= 0; b--) begin
                if (in[g*8 + b]) begin
                    grp_low[g] = 3'(b);
                end
            end
        end
        for (int g = 3; g >= 0; g--) begin
            if (grp_any[g]) begin
                grp_sel = 2'(g);
            end
        end
    end

    assign idx = {grp_sel, grp_low[grp_sel]};
    assign any = |grp_any;

endmodule

// File: rtl/request_encoder32_5.sv
// request_encoder32_5: sequential 32->5 encoder. Loads a request vector and
// emits the index of each set bit, lowest first, one per out handshake.
//   clock, reset_n        : clock, synchronous active-low reset
//   en, load_valid, req   : load side; a load is taken in IDLE when load_valid && en
//   load_ready            : high in IDLE
//   flush                 : abort current batch (count held, no done pulse)
//   out_valid, out_ready  : emit handshake; idx/onehot valid while out_valid
//   idx, onehot           : lowest pending index and its decoded form
//   count                 : indices emitted in the current batch
//   done                  : one-cycle pulse after a batch completes
//   state                 : current FSM state, for observation
// Handshakes: a transfer happens on a rising clock edge where valid && ready;
// out_valid, idx and onehot hold steady until that transfer occurs.
module request_encoder32_5
    import request_encoder32_5_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             flush,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output req_state_e       state
);

    req_state_e       state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             any;
    logic             fire;
    logic [N-1:0]     cleared;

    priority_enc32_5 u_penc (
        .in  (pending_q),
        .idx (idx),
        .any (any)
    );

    assign out_valid  = (state_q == ST_SCAN) && any;
    assign load_ready = (state_q == ST_IDLE);
    assign onehot     = out_valid ? idx_to_onehot(idx) : '0;
    assign fire       = out_valid && out_ready;
    assign cleared    = pending_q & ~onehot;
    assign count      = count_q;
    assign done       = done_q;
    assign state      = state_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        done_d    = 1'b0;
        if (flush) begin
            pending_d = '0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_valid && en) begin
                        pending_d = req;
                        count_d   = '0;
                        // An empty request completes immediately.
                        if (req != '0) begin
                            state_d = ST_SCAN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (fire) begin
                        pending_d = cleared;
                        count_d   = count_q + CNT_W'(1);
                        if (cleared == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

endmodule
